// File: rtl/fpu_pkg.sv
// Shared FPU-sharer definitions: operand width, in-flight tracking entry and
// the RUN/DRAIN encoding used by the fadd/fmul/fdiv arbiters.
package fpu_pkg;

  localparam int FP_W = 32;
  localparam logic [7:0] FP_EXP_ONES = 8'hFF;

  // Widest requester id (NREQ <= 8); narrower ids are zero-extended into it.
  localparam int ID_MAXW = 3;

  typedef struct packed {
    logic               vld;
    logic [ID_MAXW-1:0] id;
  } inflight_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_t;

  // Sign flip turns x1 + x2 into x1 - x2; NaN payloads pass through the fadd.
  function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] x);
    return {~x[FP_W-1], x[FP_W-2:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner only when the grant is enabled.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   i_req,
  input  logic           i_en,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_gid,
  output logic           o_valid
);

  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gid;
  logic           w_found;
  int             w_idx;

  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gid          = IDW'(w_idx);
      end
    end
  end

  assign o_grant = i_en ? w_grant : '0;
  assign o_gid   = w_gid;
  assign o_valid = i_en & w_found;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (int'(w_gid) == N - 1) ? '0 : w_gid + 1'b1;
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd among NREQ requesters with round-robin issue,
// id tracking, result routing, drain/flush and a saturating overflow count.
// Optional subtract support is enabled with `define FADD_ARB_FSUB_EN.
//
// Handshake: req_valid[i] with operands held stable until req_grant[i]; the
// grant cycle consumes them. rsp_valid is a one-cycle strobe, no backpressure.
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int FADD_LAT = 2,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_x1,
  input  logic [NREQ*32-1:0] req_x2,
`ifdef FADD_ARB_FSUB_EN
  input  logic [NREQ-1:0]    req_sub,
`endif
  output logic [NREQ-1:0]    req_grant,
  input  logic               flush,
  output logic               flush_done,
  output logic [31:0]        fa_x1,
  output logic [31:0]        fa_x2,
  output logic               fa_ready,
  input  logic [31:0]        fa_y,
  input  logic               fa_ovf,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_y,
  output logic               rsp_ovf,
  output logic               busy,
  output logic [15:0]        ovf_cnt,
  output logic               dbg_state
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  inflight_t       r_pipe [FADD_LAT];
  inflight_t       w_last;
  logic [NREQ-1:0] r_rsp_valid;
  logic [31:0]     r_rsp_y;
  logic            r_rsp_ovf;
  logic [15:0]     r_ovf_cnt;
  logic            w_issue_en;
  logic            w_issue;
  logic [IDW-1:0]  w_gid;
  logic            w_pipe_any;
  logic            w_empty;

  // Flush wins over a same-cycle request; reset also blocks issue.
  assign w_issue_en = rstn && (r_state == ST_RUN) && !flush;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (req_valid),
    .i_en    (w_issue_en),
    .o_grant (req_grant),
    .o_gid   (w_gid),
    .o_valid (w_issue)
  );

  always_comb begin
    fa_x1 = '0;
    fa_x2 = '0;
    if (w_issue) begin
      fa_x1 = req_x1[FP_W*int'(w_gid) +: FP_W];
      fa_x2 = req_x2[FP_W*int'(w_gid) +: FP_W];
`ifdef FADD_ARB_FSUB_EN
      if (req_sub[w_gid]) fa_x2 = fp_negate(fa_x2);
`endif
    end
  end

  assign fa_ready = w_issue;

  // In-flight ids travel alongside the fadd pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < FADD_LAT; j++) r_pipe[j] <= '0;
    end else begin
      r_pipe[0].vld <= w_issue;
      r_pipe[0].id  <= ID_MAXW'(w_gid);
      for (int j = 1; j < FADD_LAT; j++) r_pipe[j] <= r_pipe[j-1];
    end
  end

  assign w_last = r_pipe[FADD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      r_rsp_ovf   <= 1'b0;
      r_ovf_cnt   <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_last.vld) begin
        r_rsp_valid <= NREQ'(1) << w_last.id;
        r_rsp_y     <= fa_y;
        r_rsp_ovf   <= fa_ovf;
        if (fa_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_pipe_any = 1'b0;
    for (int j = 0; j < FADD_LAT; j++) w_pipe_any = w_pipe_any | r_pipe[j].vld;
  end

  assign busy      = w_pipe_any | (|r_rsp_valid);
  assign w_empty   = !busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_ovf   = r_rsp_ovf;
  assign ovf_cnt   = r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    flush_done = (r_state == ST_DRAIN) && w_empty;
    dbg_state  = r_state;
  end

endmodule
